ps2_kbd_event_queue: RTL and testbench
======================================

# ps2_kbd_event_queue

Scancode-to-key-event decoder and buffer between the PS/2 keyboard receiver and the SoC's keyboard register interface. It consumes raw set-2 bytes (code plus one-cycle strobe plus error pulse) and folds the E0/F0/E1 prefix sequences into single key events. Completed events are queued in a FIFO that the SoC drains with a valid/ready pop. Error and overflow status are exposed for software.

## Interface
- DEPTH, 16: FIFO entries; power of two, 4..256
- ERR_CNT_W, 8: width of the saturating error counter
- clk  in  1  system clock
- reset_ni  in  1  asynchronous active-low reset
- ps2_code_i  in  8  received scancode byte, valid when strobe high
- ps2_strobe_i  in  1  one-cycle pulse per received byte
- ps2_err_i  in  1  one-cycle pulse on a receiver framing/parity error
- event_o  out  10  head event: [9]=break, [8]=extended, [7:0]=code
- event_valid_o  out  1  FIFO non-empty
- event_ready_i  in  1  pop head when valid and ready
- level_o  out  $clog2(DEPTH)+1  current FIFO occupancy
- overflow_o  out  1  sticky: an event was dropped because the FIFO was full
- overflow_clr_i  in  1  clears overflow_o
- err_cnt_o  out  ERR_CNT_W  saturating count of ps2_err_i pulses

## Operation
- Decoder FSM states:
  - IDLE
  - EXT (E0 seen)
  - BRK (F0 seen)
  - EXT_BRK (E0 F0 seen)
  - PAUSE (E1 seen, skipping)
- Transitions on strobe:
  - IDLE: E0->EXT, F0->BRK, E1->PAUSE with skip counter=7. Any other byte emits {0,0,code}.
  - EXT: F0->EXT_BRK, E0 stays in EXT. Other bytes emit {0,1,code} and return to IDLE.
  - BRK: emits {1,0,code}, then IDLE.
  - EXT_BRK: emits {1,1,code}, then IDLE.
  - PAUSE: decrements the skip counter on each byte. At 0 it emits {0,1,0xE1}, then IDLE. The 7 skipped bytes never emit.
- ps2_err_i forces IDLE, clears the skip counter and increments err_cnt_o, saturating at all-ones. If err and strobe coincide, err wins and the byte is discarded.
- FIFO write on emit when not full. Full: the event is dropped and overflow_o is set.
- Full with a pop in the same cycle: the write is accepted and level is unchanged.
- Empty with an emit: no combinational bypass.
- Pop and emit in the same cycle at non-empty, non-full: level is unchanged.
- overflow_clr_i and a drop in the same cycle: overflow_o stays set, because set wins.
- Pointers wrap modulo DEPTH. level_o ranges 0..DEPTH.
- Reset values:
  - FSM=IDLE
  - level_o=0, event_valid_o=0
  - event_o=0
  - overflow_o=0
  - err_cnt_o=0
  - pointers=0
  - filter register invalid
- Reset asserted mid-sequence discards the partial prefix and all queued events.

## Timing
- Final byte strobe in cycle N -> event written at the end of N -> event_valid_o and event_o valid in N+1.
- event_o is stable while valid and not popped.
- A pop at the end of cycle M presents the next entry in M+1.
- Back-to-back strobes on consecutive cycles must be accepted. There is no input backpressure.
- level_o and overflow_o are registered and update the cycle after the causing event.

## Configuration
- PS2_KBD_TYPEMATIC_FILTER_EN defined:
  - A make event equal to the last emitted make, on both code and extended bit, is discarded before the FIFO.
  - Any emitted break, ps2_err_i, or reset invalidates the last-make register.
  - Pause events are never filtered.
- Undefined: every decoded make, including typematic repeats, is queued, and the filter register is not built.

## Structure
- Package ps2_kbd_pkg holds:
  - typedef kbd_event_t (packed: brk, ext, code[7:0])
  - decoder state enum
  - constants PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BRK=8'hF0, PS2_PREFIX_PAUSE=8'hE1, PAUSE_SKIP=7
- One sub-module, kbd_event_fifo: a synchronous FIFO parameterised on DEPTH and width. It provides the show-ahead head, level and full/empty flags.
- The decoder FSM and filter live in the top module.

## Test plan
- Bytes 1C, then F0 1C -> events 0x01C then 0x21C, in order; level peaks at 2 if not popped.
- E0 75, then E0 F0 75 -> events 0x175 then 0x375.
- E1 14 77 E1 F0 14 F0 77 -> exactly one event 0x1E1; the FSM returns to IDLE.
- Fill with 17 makes and ready low, DEPTH=16 -> level_o=16, overflow_o=1, and the 17th event is absent.
  - Then pop with overflow_clr_i -> overflow_o=0 and level 15.
- E0, then ps2_err_i, then 1C -> event 0x01C (no ext bit) and err_cnt_o=1.
  - 300 err pulses with ERR_CNT_W=8 -> err_cnt_o=255.
- With the filter macro defined, 1C 1C 1C F0 1C 1C -> events 0x01C, 0x21C, 0x01C.
  - Without the macro -> all five events are queued.

Source files
------------

// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 set-2 key event decoder and its queue.
package ps2_kbd_pkg;

    localparam logic [7:0]  PS2_PREFIX_EXT   = 8'hE0;
    localparam logic [7:0]  PS2_PREFIX_BRK   = 8'hF0;
    localparam logic [7:0]  PS2_PREFIX_PAUSE = 8'hE1;
    localparam int unsigned PAUSE_SKIP       = 7;
    localparam int unsigned EVENT_W          = 10;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } kbd_event_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } dec_state_e;

    function automatic kbd_event_t mk_event(input logic brk, input logic ext,
                                            input logic [7:0] code);
        kbd_event_t ev;
        ev.brk  = brk;
        ev.ext  = ext;
        ev.code = code;
        return ev;
    endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// Show-ahead synchronous FIFO; a write while full is accepted only when a pop frees a slot.
module kbd_event_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 10,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [LW-1:0]    level_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             push, pop;

    assign full_o    = (level_q == LW'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign pop       = rd_en_i && !empty_o;
    assign push      = wr_en_i && (!full_o || pop);
    assign level_o   = level_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd_event_queue.sv
// Folds PS/2 set-2 prefix bytes into key events and queues them for software.
// Define PS2_KBD_TYPEMATIC_FILTER_EN to drop repeated makes of the same key.
module ps2_kbd_event_queue
    import ps2_kbd_pkg::*;
#(
    parameter  int DEPTH     = 16,
    parameter  int ERR_CNT_W = 8,
    localparam int LW        = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset_ni,
    input  logic [7:0]           ps2_code_i,
    input  logic                 ps2_strobe_i,
    input  logic                 ps2_err_i,
    output logic [9:0]           event_o,
    output logic                 event_valid_o,
    input  logic                 event_ready_i,
    output logic [LW-1:0]        level_o,
    output logic                 overflow_o,
    input  logic                 overflow_clr_i,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    dec_state_e           state_q, state_d;
    logic [2:0]           skip_q, skip_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 overflow_q, overflow_d;
    logic                 emit, filtered, wr_en, pop, drop;
    kbd_event_t           emit_evt;
    logic [EVENT_W-1:0]   head;
    logic                 fifo_full, fifo_empty;

    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        emit     = 1'b0;
        emit_evt = '0;
        if (ps2_err_i) begin
            state_d = ST_IDLE;
            skip_d  = '0;
        end else if (ps2_strobe_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (ps2_code_i == PS2_PREFIX_EXT) begin
                        state_d = ST_EXT;
                    end else if (ps2_code_i == PS2_PREFIX_BRK) begin
                        state_d = ST_BRK;
                    end else if (ps2_code_i == PS2_PREFIX_PAUSE) begin
                        state_d = ST_PAUSE;
                        skip_d  = 3'(PAUSE_SKIP);
                    end else begin
                        emit     = 1'b1;
                        emit_evt = mk_event(1'b0, 1'b0, ps2_code_i);
                    end
                end
                ST_EXT: begin
                    if (ps2_code_i == PS2_PREFIX_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else if (ps2_code_i != PS2_PREFIX_EXT) begin
                        emit     = 1'b1;
                        emit_evt = mk_event(1'b0, 1'b1, ps2_code_i);
                        state_d  = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    emit     = 1'b1;
                    emit_evt = mk_event(1'b1, 1'b0, ps2_code_i);
                    state_d  = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    emit     = 1'b1;
                    emit_evt = mk_event(1'b1, 1'b1, ps2_code_i);
                    state_d  = ST_IDLE;
                end
                ST_PAUSE: begin
                    // The byte that brings the skip count to zero completes the pause sequence.
                    if (skip_q <= 3'd1) begin
                        skip_d   = '0;
                        emit     = 1'b1;
                        emit_evt = mk_event(1'b0, 1'b1, PS2_PREFIX_PAUSE);
                        state_d  = ST_IDLE;
                    end else begin
                        skip_d = skip_q - 3'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    skip_d  = '0;
                end
            endcase
        end
    end

`ifdef PS2_KBD_TYPEMATIC_FILTER_EN
    logic [8:0] last_make_q;
    logic       last_valid_q;
    logic       pause_emit;

    assign pause_emit = (state_q == ST_PAUSE);
    assign filtered   = emit && !emit_evt.brk && !pause_emit && last_valid_q &&
                        (last_make_q == {emit_evt.ext, emit_evt.code});

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            last_make_q  <= '0;
            last_valid_q <= 1'b0;
        end else if (ps2_err_i || (emit && emit_evt.brk)) begin
            last_valid_q <= 1'b0;
        end else if (emit && !pause_emit) begin
            last_make_q  <= {emit_evt.ext, emit_evt.code};
            last_valid_q <= 1'b1;
        end
    end
`else
    assign filtered = 1'b0;
`endif

    assign wr_en = emit && !filtered;
    assign pop   = event_valid_o && event_ready_i;
    assign drop  = wr_en && fifo_full && !pop;

    // A drop in the same cycle as a clear leaves the flag set.
    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr_i) begin
            overflow_d = 1'b0;
        end
        err_cnt_d = err_cnt_q;
        if (ps2_err_i && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= ST_IDLE;
            skip_q     <= '0;
            err_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            err_cnt_q  <= err_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    kbd_event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EVENT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_ni    (reset_ni),
        .wr_en_i   (wr_en),
        .wr_data_i (emit_evt),
        .rd_en_i   (event_ready_i),
        .rd_data_o (head),
        .level_o   (level_o),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign event_valid_o = !fifo_empty;
    assign event_o       = fifo_empty ? '0 : head;
    assign overflow_o    = overflow_q;
    assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_ps2_kbd_event_queue.sv
// Scoreboard bench for ps2_kbd_event_queue; honours PS2_KBD_TYPEMATIC_FILTER_EN when defined.
module tb_ps2_kbd_event_queue;

    localparam int DEPTH     = 16;
    localparam int ERR_CNT_W = 8;
    localparam int LW        = $clog2(DEPTH) + 1;

    logic                 clk;
    logic                 resetNi;
    logic [7:0]           ps2Code;
    logic                 ps2Strobe;
    logic                 ps2Err;
    logic [9:0]           eventOut;
    logic                 eventValid;
    logic                 eventReady;
    logic [LW-1:0]        level;
    logic                 overflow;
    logic                 overflowClr;
    logic [ERR_CNT_W-1:0] errCnt;

    logic [9:0] expQ [$];
    int         checks = 0;
    int         errors = 0;

    ps2_kbd_event_queue #(
        .DEPTH     (DEPTH),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk            (clk),
        .reset_ni       (resetNi),
        .ps2_code_i     (ps2Code),
        .ps2_strobe_i   (ps2Strobe),
        .ps2_err_i      (ps2Err),
        .event_o        (eventOut),
        .event_valid_o  (eventValid),
        .event_ready_i  (eventReady),
        .level_o        (level),
        .overflow_o     (overflow),
        .overflow_clr_i (overflowClr),
        .err_cnt_o      (errCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one strobed byte for exactly one cycle; consecutive calls are back-to-back.
    task applyStimulus(input logic [7:0] b);
        ps2Code   = b;
        ps2Strobe = 1'b1;
        @(posedge clk); #1;
        ps2Strobe = 1'b0;
    endtask

    task pulseErr(input int n);
        ps2Err = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        ps2Err = 1'b0;
    endtask

    task drain(input string name);
        eventReady = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (expQ.size() == 0 && !eventValid) break;
            @(posedge clk); #1;
        end
        eventReady = 1'b0;
        checkOutput({name, "_missing"}, expQ.size(), 0);
        checkOutput({name, "_level0"}, 32'(level), 0);
        expQ.delete();
    endtask

    // Pops happen at the next rising edge whenever valid and ready are both high here.
    always @(negedge clk) begin
        if (resetNi && eventValid && eventReady) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_event: got 0x%0h expected none", eventOut);
            end else begin
                checkOutput("event", 32'(eventOut), 32'(expQ.pop_front()));
            end
        end
    end

    initial begin
        resetNi     = 1'b0;
        ps2Code     = 8'h00;
        ps2Strobe   = 1'b0;
        ps2Err      = 1'b0;
        eventReady  = 1'b0;
        overflowClr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_level", 32'(level), 0);
        checkOutput("rst_valid", 32'(eventValid), 0);
        checkOutput("rst_event", 32'(eventOut), 0);
        checkOutput("rst_overflow", 32'(overflow), 0);
        checkOutput("rst_errcnt", 32'(errCnt), 0);
        resetNi = 1'b1;
        @(posedge clk); #1;

        // Plain make then break of the same key
        applyStimulus(8'h1C); expQ.push_back(10'h01C);
        checkOutput("t1_valid_next_cycle", 32'(eventValid), 1);
        checkOutput("t1_head", 32'(eventOut), 32'h01C);
        applyStimulus(8'hF0);
        applyStimulus(8'h1C); expQ.push_back(10'h21C);
        checkOutput("t1_level2", 32'(level), 2);
        drain("t1");

        // Extended make and extended break
        applyStimulus(8'hE0);
        applyStimulus(8'h75); expQ.push_back(10'h175);
        applyStimulus(8'hE0);
        applyStimulus(8'hF0);
        applyStimulus(8'h75); expQ.push_back(10'h375);
        checkOutput("t2_level2", 32'(level), 2);
        drain("t2");

        // Pause sequence collapses to one event, then the FSM is back in IDLE
        applyStimulus(8'hE1);
        applyStimulus(8'h14);
        applyStimulus(8'h77);
        applyStimulus(8'hE1);
        applyStimulus(8'hF0);
        applyStimulus(8'h14);
        applyStimulus(8'hF0);
        applyStimulus(8'h77); expQ.push_back(10'h1E1);
        checkOutput("t3_one_event", 32'(level), 1);
        applyStimulus(8'h1C); expQ.push_back(10'h01C);
        drain("t3");

        // Overflow: 17 distinct makes into a 16-deep queue
        for (int i = 0; i < 17; i++) begin
            applyStimulus(8'h30 + 8'(i));
            if (i < 16) expQ.push_back({2'b00, 8'h30 + 8'(i)});
        end
        checkOutput("t4_level_full", 32'(level), 16);
        checkOutput("t4_overflow_set", 32'(overflow), 1);
        overflowClr = 1'b1;
        eventReady  = 1'b1;
        @(posedge clk); #1;
        overflowClr = 1'b0;
        eventReady  = 1'b0;
        checkOutput("t4_overflow_clr", 32'(overflow), 0);
        checkOutput("t4_level_15", 32'(level), 15);
        drain("t4");

        // Error aborts a prefix; coincident err and strobe discards the byte
        applyStimulus(8'hE0);
        pulseErr(1);
        applyStimulus(8'h1C); expQ.push_back(10'h01C);
        checkOutput("t5_errcnt1", 32'(errCnt), 1);
        ps2Code   = 8'h2A;
        ps2Strobe = 1'b1;
        ps2Err    = 1'b1;
        @(posedge clk); #1;
        ps2Strobe = 1'b0;
        ps2Err    = 1'b0;
        checkOutput("t5_errcnt2", 32'(errCnt), 2);
        checkOutput("t5_byte_dropped", 32'(level), 1);
        pulseErr(300);
        checkOutput("t5_errcnt_sat", 32'(errCnt), 255);
        drain("t5");

        // Reset mid-prefix discards queued events and the partial sequence
        applyStimulus(8'h11);
        applyStimulus(8'hE0);
        checkOutput("t6_level_before", 32'(level), 1);
        resetNi = 1'b0;
        @(posedge clk); #1;
        expQ.delete();
        checkOutput("t6_rst_level", 32'(level), 0);
        checkOutput("t6_rst_valid", 32'(eventValid), 0);
        checkOutput("t6_rst_errcnt", 32'(errCnt), 0);
        resetNi = 1'b1;
        @(posedge clk); #1;
        applyStimulus(8'h75); expQ.push_back(10'h075);
        drain("t6");

        // Typematic repeats
        applyStimulus(8'h1C); expQ.push_back(10'h01C);
        applyStimulus(8'h1C);
`ifndef PS2_KBD_TYPEMATIC_FILTER_EN
        expQ.push_back(10'h01C);
`endif
        applyStimulus(8'h1C);
`ifndef PS2_KBD_TYPEMATIC_FILTER_EN
        expQ.push_back(10'h01C);
`endif
        applyStimulus(8'hF0);
        applyStimulus(8'h1C); expQ.push_back(10'h21C);
        applyStimulus(8'h1C); expQ.push_back(10'h01C);
`ifdef PS2_KBD_TYPEMATIC_FILTER_EN
        checkOutput("t7_level", 32'(level), 3);
`else
        checkOutput("t7_level", 32'(level), 5);
`endif
        drain("t7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
